bin_bcd_dig: RTL and testbench
==============================

# bin_bcd_dig

Single-digit binary-to-BCD converter. It takes a 4-bit unsigned binary value (0–15) and produces a 5-bit two-digit BCD result: a 1-bit tens digit and a 4-bit units digit. It sits between binary arithmetic/counter logic and display or decimal-formatting logic. The result is registered and carries a valid flag.

## Interface
- Parameters: none.
- Clock and reset: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: A3..A0 carry a value to convert this cycle.
- `A3` input 1: binary input MSB (weight 8).
- `A2` input 1: binary input (weight 4).
- `A1` input 1: binary input (weight 2).
- `A0` input 1: binary input LSB (weight 1).
- `B4` output 1: BCD tens digit (0 or 1).
- `B3` output 1: BCD units digit MSB (weight 8).
- `B2` output 1: BCD units digit (weight 4).
- `B1` output 1: BCD units digit (weight 2).
- `B0` output 1: BCD units digit LSB (weight 1).
- `out_valid` output 1: B4..B0 hold a freshly converted result.

## Operation
- Input value: v = {A3,A2,A1,A0}, unsigned 0..15.
- If v ≤ 9: B4 = 0 and {B3..B0} = v.
- If v ≥ 10: B4 = 1 and {B3..B0} = v − 10 (result range 0..5).
- Equivalent check: 10·B4 + {B3..B0} = v for all 16 inputs.
- The units digit never exceeds 9; codes 1010–1111 never appear on B3..B0.
- All 16 input codes are legal. There is no error output.
- When `in_valid` = 0, B4..B0 hold their last converted value.

## Timing
- Reset (`rst_n` = 0, asynchronous):
  - B4..B0 = 00000 immediately.
  - `out_valid` = 0 immediately.
- Reset release is sampled synchronously. The first conversion can be captured on the first rising edge with `rst_n` = 1.
- Latency is 1 cycle. A rising edge with `in_valid` = 1 loads the converted result and sets `out_valid` = 1.
- A rising edge with `in_valid` = 0 clears `out_valid` to 0 and leaves B4..B0 unchanged.
- Back-to-back `in_valid` = 1 gives one result per cycle. There is no stall or backpressure.
- Reset asserted mid-stream discards any pending result. Outputs go to zero and `out_valid` goes to 0 at once.
- Input changes between clock edges have no effect on the outputs.

## Configuration
- `BIN_BCD_DIG_COMB_EN` defined:
  - B4..B0 are purely combinational from A3..A0, with zero latency.
  - `out_valid` = `in_valid`, combinationally.
  - `clk` and `rst_n` are unused.
- `BIN_BCD_DIG_COMB_EN` undefined (default):
  - Registered behaviour exactly as in Timing.

## Test plan
- Reset: assert `rst_n` = 0 with A = 1111 and `in_valid` = 1 → B4..B0 = 00000 and `out_valid` = 0 throughout reset.
- Exhaustive sweep: apply v = 0..15 back-to-back with `in_valid` = 1 → each value appears one cycle later. Spot checks: 9 → 0_1001, 10 → 1_0000, 15 → 1_0101; `out_valid` stays 1.
- Hold: convert 12 (→ 1_0010), then drive A = 0011 with `in_valid` = 0 → outputs stay 1_0010 and `out_valid` = 0.
- Mid-stream reset: stream 13 and 14, then pulse `rst_n` low between edges → outputs = 00000 immediately. The next valid input 7 yields 0_0111 one cycle after reset release.
- Combinational build (`BIN_BCD_DIG_COMB_EN` defined): step A through 0..15, 100 time units apart, with no clock → B4..B0 track the input in the same time step, e.g. 11 → 1_0001.

Source files
------------

// File: rtl/bin_bcd_dig.sv
// Single-digit binary-to-BCD converter: 4-bit value in, registered tens/units digits out.
// Define BIN_BCD_DIG_COMB_EN for a purely combinational, zero-latency variant.
module bin_bcd_dig (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic A3,
    input  logic A2,
    input  logic A1,
    input  logic A0,
    output logic B4,
    output logic B3,
    output logic B2,
    output logic B1,
    output logic B0,
    output logic out_valid
);

    logic [3:0] binVal;
    logic [4:0] bcdVal;

    assign binVal = {A3, A2, A1, A0};

    // Values 10..15 carry into the tens digit; the units digit stays within 0..5.
    always_comb begin
        bcdVal = {1'b0, binVal};
        if (binVal > 4'd9) begin
            bcdVal = {1'b1, binVal - 4'd10};
        end
    end

`ifdef BIN_BCD_DIG_COMB_EN

    assign {B4, B3, B2, B1, B0} = bcdVal;
    assign out_valid            = in_valid;

`else

    logic [4:0] bcd_q;
    logic [4:0] bcd_d;
    logic       valid_q;
    logic       valid_d;

    always_comb begin
        bcd_d   = bcd_q;
        valid_d = in_valid;
        if (in_valid) begin
            bcd_d = bcdVal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q   <= 5'd0;
            valid_q <= 1'b0;
        end else begin
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
        end
    end

    assign {B4, B3, B2, B1, B0} = bcd_q;
    assign out_valid            = valid_q;

`endif

endmodule

// File: tb/tb_bin_bcd_dig.sv
// Directed self-checking bench for bin_bcd_dig (registered build by default,
// combinational sweep when BIN_BCD_DIG_COMB_EN is defined).
module tb_bin_bcd_dig;

    logic clk;
    logic rst_n;
    logic in_valid;
    logic A3, A2, A1, A0;
    logic B4, B3, B2, B1, B0;
    logic out_valid;

    int checkCount;
    int errorCount;

    // Hand-computed BCD results {tens, units} for inputs 0..15
    logic [4:0] expTable [16] = '{
        5'b0_0000, 5'b0_0001, 5'b0_0010, 5'b0_0011,
        5'b0_0100, 5'b0_0101, 5'b0_0110, 5'b0_0111,
        5'b0_1000, 5'b0_1001, 5'b1_0000, 5'b1_0001,
        5'b1_0010, 5'b1_0011, 5'b1_0100, 5'b1_0101
    };

    bin_bcd_dig dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A3        (A3),
        .A2        (A2),
        .A1        (A1),
        .A0        (A0),
        .B4        (B4),
        .B3        (B3),
        .B2        (B2),
        .B1        (B1),
        .B0        (B0),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [5:0] observed, input logic [5:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    task automatic driveInputs(input logic [3:0] value, input logic valid);
        {A3, A2, A1, A0} = value;
        in_valid = valid;
    endtask

    // Drive on the falling edge, then sample 1 time unit after the next rising edge
    task automatic applyStimulus(input logic [3:0] value, input logic valid);
        @(negedge clk);
        driveInputs(value, valid);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] observed();
        return {out_valid, B4, B3, B2, B1, B0};
    endfunction

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst_n      = 1'b0;
        driveInputs(4'd15, 1'b1);

`ifdef BIN_BCD_DIG_COMB_EN
        rst_n = 1'b1;
        for (int v = 0; v < 16; v++) begin
            driveInputs(v[3:0], 1'b1);
            #1;
            checkOutput($sformatf("comb_%0d", v), observed(), {1'b1, expTable[v]});
            #99;
        end
        driveInputs(4'd11, 1'b0);
        #1;
        checkOutput("comb_valid_low", observed(), {1'b0, 5'b1_0001});
`else
        #1;
        checkOutput("reset_immediate", observed(), 6'b0_00000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("reset_hold_%0d", i), observed(), 6'b0_00000);
        end

        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 16; v++) begin
            applyStimulus(v[3:0], 1'b1);
            checkOutput($sformatf("sweep_%0d", v), observed(), {1'b1, expTable[v]});
        end

        applyStimulus(4'd12, 1'b1);
        checkOutput("hold_load_12", observed(), 6'b1_10010);
        applyStimulus(4'd3, 1'b0);
        checkOutput("hold_idle_1", observed(), 6'b0_10010);
        applyStimulus(4'd9, 1'b0);
        checkOutput("hold_idle_2", observed(), 6'b0_10010);

        // Input wiggles between edges must not reach the outputs
        driveInputs(4'd5, 1'b1);
        #2;
        checkOutput("between_edges", observed(), 6'b0_10010);

        applyStimulus(4'd13, 1'b1);
        checkOutput("stream_13", observed(), 6'b1_10011);
        applyStimulus(4'd14, 1'b1);
        checkOutput("stream_14", observed(), 6'b1_10100);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_immediate", observed(), 6'b0_00000);
        @(posedge clk);
        #1;
        checkOutput("midreset_held", observed(), 6'b0_00000);

        @(negedge clk);
        rst_n = 1'b1;
        driveInputs(4'd7, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("after_reset_7", observed(), 6'b1_00111);
        applyStimulus(4'd7, 1'b0);
        checkOutput("after_reset_idle", observed(), 6'b0_00111);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
